gpio_input_filter: RTL

Conditioning stage directly upstream of the GPIO peripheral: synchronises the raw external input pins, debounces each bit, and drives the debounced vector into the GPIO block's `gpio_in`. It also detects rising and falling edges on the debounced bits and latches them into a memory-mapped interrupt-pending register with write-1-to-clear semantics. The pending register shares the CPU load/store bus with GPIO, in the address window immediately after the GPIO window.

---
 rtl/gpio_pkg.sv | 58 +++++
 rtl/gpio_input_filter_if.sv | 31 +++
 rtl/debounce_bit.sv | 58 +++++
 rtl/gpio_input_filter.sv | 90 +++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gpio_pkg: shared GPIO address map and interrupt register decode.  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package gpio_pkg;

  localparam logic [31:0] GPIO_BASE = 32'ha000_0000;
  localparam logic [31:0] GPIO_SIZE = 32'h0000_0100;
  // The interrupt window sits directly after the GPIO window
  localparam logic [31:0] IRQ_BASE  = GPIO_BASE + GPIO_SIZE;
  localparam logic [31:0] IRQ_SIZE  = 32'h0000_0100;

  localparam logic [31:0] IRQ_PENDING_OFS = 32'h0;
  localparam logic [31:0] IRQ_RISE_EN_OFS = 32'h4;
  localparam logic [31:0] IRQ_FALL_EN_OFS = 32'h8;
  localparam logic [31:0] IRQ_LEVEL_OFS   = 32'hC;

  typedef enum logic [1:0] {
    REG_PENDING = 2'd0,
    REG_RISE_EN = 2'd1,
    REG_FALL_EN = 2'd2,
    REG_LEVEL   = 2'd3
  } irq_reg_e;

  typedef struct packed {
    logic     hit;
    irq_reg_e sel;
  } irq_decode_t;

  function automatic irq_decode_t irq_decode(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [31:0] size
  );
    irq_decode_t d;
    logic [31:0] ofs;
    logic [32:0] lim;
    logic        in_win;
    ofs    = addr - base;
    lim    = {1'b0, base} + {1'b0, size};
    in_win = (addr >= base) && ({1'b0, addr} < lim);
    d.hit  = 1'b0;
    d.sel  = REG_PENDING;
    if (in_win && (ofs[1:0] == 2'b00)) begin
      case (ofs)
        IRQ_PENDING_OFS: begin d.hit = 1'b1; d.sel = REG_PENDING; end
        IRQ_RISE_EN_OFS: begin d.hit = 1'b1; d.sel = REG_RISE_EN; end
        IRQ_FALL_EN_OFS: begin d.hit = 1'b1; d.sel = REG_FALL_EN; end
        IRQ_LEVEL_OFS:   begin d.hit = 1'b1; d.sel = REG_LEVEL;   end
        default:         d.hit = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_input_filter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gpio_input_filter_if: CPU load/store bus for the IRQ registers.   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface gpio_input_filter_if;

  logic [31:0] address;
  logic [31:0] write_data;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] read_data;

  modport master (
    output address,
    output write_data,
    output write_enable,
    output read_enable,
    input  read_data
  );

  modport slave (
    input  address,
    input  write_data,
    input  write_enable,
    input  read_enable,
    output read_data
  );

endinterface
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | debounce_bit: 2-flop synchroniser, debounce counter, edge pulses. |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic pin,
  output logic      filt,
  output logic      rise,
  output logic      fall
);

  localparam int             CW         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  C_CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_filt;
  logic [CW-1:0] r_cnt;
  logic          w_differ;
  logic          w_accept;

  assign w_differ = (r_s2 != r_filt);
  assign w_accept = w_differ && (r_cnt == C_CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1 <= pin;
      r_s2 <= r_s1;
      // Any return to the accepted level restarts the count from zero
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_filt <= r_s2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Pulses are valid in the cycle before filt flips, so the pending
  // register can latch them on the same edge that updates filt.
  assign filt = r_filt;
  assign rise = w_accept &  r_s2;
  assign fall = w_accept & ~r_s2;

endmodule
`default_nettype wire

// File: rtl/gpio_input_filter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gpio_input_filter: debounced GPIO inputs with W1C edge interrupts.|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module gpio_input_filter
  import gpio_pkg::*;
#(
  parameter int          WIDTH           = 32,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] IRQ_BASE        = 32'ha000_0100,
  parameter logic [31:0] IRQ_SIZE        = 32'h0000_0100
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [WIDTH-1:0] pin_in,
  output logic      [WIDTH-1:0] filtered_out,
  gpio_input_filter_if.slave    bus,
  output logic                  irq
);

  logic [WIDTH-1:0] w_filt;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  irq_decode_t      w_dec;
  logic             w_wr_pending;
  logic             w_wr_rise_en;
  logic             w_wr_fall_en;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .pin  (pin_in[gi]),
      .filt (w_filt[gi]),
      .rise (w_rise[gi]),
      .fall (w_fall[gi])
    );
  end

  assign w_dec   = irq_decode(bus.address, IRQ_BASE, IRQ_SIZE);
  assign w_wdata = bus.write_data[WIDTH-1:0];

  assign w_wr_pending = bus.write_enable && w_dec.hit && (w_dec.sel == REG_PENDING);
  assign w_wr_rise_en = bus.write_enable && w_dec.hit && (w_dec.sel == REG_RISE_EN);
  assign w_wr_fall_en = bus.write_enable && w_dec.hit && (w_dec.sel == REG_FALL_EN);

  // Enables are sampled before this edge's write lands, and a new event
  // overrides a simultaneous W1C of the same bit.
  assign w_set = (w_rise & r_rise_en) | (w_fall & r_fall_en);
  assign w_clr = w_wr_pending ? w_wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_wr_rise_en) r_rise_en <= w_wdata;
      if (w_wr_fall_en) r_fall_en <= w_wdata;
    end
  end

  always_comb begin
    bus.read_data = '0;
    if (bus.read_enable && w_dec.hit) begin
      case (w_dec.sel)
        REG_PENDING: bus.read_data = 32'(r_pending);
        REG_RISE_EN: bus.read_data = 32'(r_rise_en);
        REG_FALL_EN: bus.read_data = 32'(r_fall_en);
        REG_LEVEL:   bus.read_data = 32'(w_filt);
        default:     bus.read_data = '0;
      endcase
    end
  end

  assign filtered_out = w_filt;
  assign irq          = |r_pending;

endmodule
`default_nettype wire
